memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of REQ cycles to wait for dm_ack before faulting; legal range 2..255.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 MemRead_M, MemWrite_M, Branch_M  in  1 each  control bits from the execute-stage pipeline register.
REQ-005 aluResult_M  in  64  byte address; writeData_M  in  64  store data; zero_M  in  1  ALU zero flag.
REQ-006 PCSrc_M  out  1  branch-taken select; readData_M  out  64  last loaded doubleword.
REQ-007 stall_M  out  1  high = upstream SHALL hold every M-stage input stable.
REQ-008 mem_fault  out  1  sticky fault flag.
REQ-009 dm_req, dm_we  out  1 each; dm_addr, dm_wdata  out  64 each  data-memory bus.
REQ-010 dm_ack, dm_err  in  1 each; dm_rdata  in  64  data-memory response.

Function
REQ-011 PCSrc_M SHALL equal Branch_M AND zero_M combinationally in every state, including FAULT.
REQ-012 The FSM SHALL have exactly four states: IDLE, REQ, DONE and FAULT.
REQ-013 In IDLE, a request SHALL be detected when exactly one of MemRead_M and MemWrite_M is high and aluResult_M[2:0]==0.
- On a request: stall_M=1 combinationally in that cycle; latch address, data and we=MemWrite_M; next state REQ; clear the timer.
REQ-014 In IDLE, MemRead_M and MemWrite_M both high, or a request with aluResult_M[2:0]!=0, SHALL cause: next state FAULT, no bus request, stall_M=0.
REQ-015 In REQ, the outputs SHALL be:
- dm_req=1, stall_M=1.
- dm_addr, dm_wdata, dm_we driven from the latches, stable for the whole state.
REQ-016 In REQ with dm_ack=1 and dm_err=0: next state DONE; if read, readData_M<=dm_rdata on that edge.
REQ-017 In REQ with dm_err=1 (with or without dm_ack): next state FAULT; readData_M unchanged.
REQ-018 In REQ without dm_ack, the timer SHALL increment; when it reaches TIMEOUT-1 with no ack, next state SHALL be FAULT.
REQ-019 DONE SHALL last exactly one cycle: stall_M=0, dm_req=0, next state IDLE unconditionally; inputs in DONE SHALL NOT start a request.
REQ-020 Stall length for an access acknowledged after N REQ cycles (N>=1) SHALL be 1+N cycles; the pipeline advances at the end of DONE.
REQ-021 FAULT SHALL be absorbing until reset: mem_fault=1, dm_req=0, stall_M=0, all memory ops ignored.
REQ-022 dm_ack, dm_err and dm_rdata SHALL be ignored outside REQ.
REQ-023 readData_M SHALL change only on a successful read (REQ-016); stores and faults SHALL leave it unchanged.
REQ-024 Outside REQ, dm_addr, dm_wdata and dm_we SHALL drive the latched values; dm_req SHALL be 0.

Reset
REQ-025 On a reset edge, the following SHALL hold from that edge onward:
- state=IDLE, timer=0, readData_M=0, latches=0.
- dm_req=0, dm_we=0, mem_fault=0.
- stall_M reflects the current inputs per REQ-013.
REQ-026 Reset asserted during REQ SHALL abandon the transaction; a late dm_ack SHALL be ignored per REQ-022.

Structure
REQ-027 The shared package mem_pkg SHALL hold:
- the state enum typedef (IDLE, REQ, DONE, FAULT);
- localparam DW=64;
- the default TIMEOUT value.
REQ-028 The timeout counter SHALL be one sub-module, access_timer, with clk, reset, clear, enable and a terminal-count output.
REQ-029 dm_req and mem_fault SHALL be driven from registered state only; the only combinational outputs SHALL be stall_M and PCSrc_M.

Verification
REQ-030 Load with 1-cycle ack: MemRead_M=1, aluResult_M=0x40, dm_ack in the first REQ cycle with dm_rdata=0xDEADBEEF -> stall_M high 2 cycles, readData_M=0xDEADBEEF, dm_addr=0x40.
REQ-031 Store with 3-cycle ack latency: MemWrite_M=1, writeData_M=0x1234 -> dm_we=1, dm_wdata=0x1234 stable for 3 REQ cycles, stall_M high 4 cycles, readData_M unchanged.
REQ-032 Timeout: TIMEOUT=4, read issued, no ack -> FAULT after 4 REQ cycles, then mem_fault=1, dm_req=0, stall_M=0; a later read issues no request.
REQ-033 Illegal requests:
- aluResult_M=0x44 read -> immediate FAULT, no dm_req.
- after reset, MemRead_M=MemWrite_M=1 -> FAULT.
REQ-034 Reset mid-REQ then dm_ack one cycle later -> IDLE, readData_M=0, no DONE; Branch_M=1, zero_M=1 -> PCSrc_M=1 throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the M-stage memory access block.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        FAULT
    } state_t;

    localparam int DW = 64;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the M stage (master) and the memory (slave).
interface memory_access_if;
    import mem_pkg::*;

    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic          dm_err;
    logic [DW-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_err, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_err, dm_rdata
    );

endinterface

// File: rtl/access_timer.sv
// Counts REQ cycles without an ack; tc flags the last cycle before a timeout fault.
module access_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= 8'd0;
        end else if (enable) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign tc = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access.sv
// M-stage load/store sequencer: issues one data-memory transaction per request,
// stalls the pipeline until it completes, and latches a sticky fault.
module memory_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead_M,
    input  logic          MemWrite_M,
    input  logic          Branch_M,
    input  logic [DW-1:0] aluResult_M,
    input  logic [DW-1:0] writeData_M,
    input  logic          zero_M,
    output logic          PCSrc_M,
    output logic [DW-1:0] readData_M,
    output logic          stall_M,
    output logic          mem_fault,
    memory_access_if.master bus
);

    state_t        state_q, state_d;
    logic [DW-1:0] addr_q, wdata_q;
    logic          we_q;
    logic          latch_en, rd_load;
    logic          timer_clear, timer_en, timer_tc;

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            readData_M <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q  <= aluResult_M;
                wdata_q <= writeData_M;
                we_q    <= MemWrite_M;
            end
            if (rd_load) begin
                readData_M <= bus.dm_rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_M     = 1'b0;
        latch_en    = 1'b0;
        rd_load     = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((MemRead_M ^ MemWrite_M) && (aluResult_M[2:0] == 3'b000)) begin
                    stall_M     = 1'b1;
                    latch_en    = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = REQ;
                end else if ((MemRead_M && MemWrite_M) ||
                             ((MemRead_M || MemWrite_M) && (aluResult_M[2:0] != 3'b000))) begin
                    state_d = FAULT;
                end
            end
            REQ: begin
                stall_M = 1'b1;
                // An error wins over a simultaneous ack; an ack on the terminal cycle still counts.
                if (bus.dm_err) begin
                    state_d = FAULT;
                end else if (bus.dm_ack) begin
                    rd_load = ~we_q;
                    state_d = DONE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_tc) begin
                        state_d = FAULT;
                    end
                end
            end
            DONE:  state_d = IDLE;
            FAULT: state_d = FAULT;
        endcase
    end

    assign PCSrc_M      = Branch_M & zero_M;
    assign mem_fault    = (state_q == FAULT);
    assign bus.dm_req   = (state_q == REQ);
    assign bus.dm_we    = we_q;
    assign bus.dm_addr  = addr_q;
    assign bus.dm_wdata = wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with TIMEOUT=4.
module tb_memory_access;
    import mem_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [DW-1:0] aluResult_M, writeData_M;
    logic          PCSrc_M, stall_M, mem_fault;
    logic [DW-1:0] readData_M;
    int            total = 0;
    int            bad = 0;

    memory_access_if bus ();

    memory_access #(
        .TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .Branch_M    (Branch_M),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .zero_M      (zero_M),
        .PCSrc_M     (PCSrc_M),
        .readData_M  (readData_M),
        .stall_M     (stall_M),
        .mem_fault   (mem_fault),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
        Branch_M = 1'b1; zero_M = 1'b1;
        aluResult_M = '0; writeData_M = '0;
        bus.dm_ack = 1'b0; bus.dm_err = 1'b0; bus.dm_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_rdata", readData_M, 64'h0);
        chk("rst_req", bus.dm_req, 1'b0);
        chk("rst_we", bus.dm_we, 1'b0);
        chk("rst_fault", mem_fault, 1'b0);
        chk("rst_addr", bus.dm_addr, 64'h0);
        chk("rst_stall", stall_M, 1'b0);
        chk("pcsrc_1", PCSrc_M, 1'b1);
        zero_M = 1'b0; #1;
        chk("pcsrc_0", PCSrc_M, 1'b0);
        zero_M = 1'b1;

        // Load, ack in first REQ cycle
        MemRead_M = 1'b1; aluResult_M = 64'h40; #1;
        chk("ld_idle_stall", stall_M, 1'b1);
        chk("ld_idle_req", bus.dm_req, 1'b0);
        tick();
        bus.dm_ack = 1'b1; bus.dm_rdata = 64'hDEADBEEF; #1;
        chk("ld_req", bus.dm_req, 1'b1);
        chk("ld_req_stall", stall_M, 1'b1);
        chk("ld_addr", bus.dm_addr, 64'h40);
        chk("ld_we", bus.dm_we, 1'b0);
        tick();
        bus.dm_ack = 1'b0; #1;
        chk("ld_done_stall", stall_M, 1'b0);
        chk("ld_done_req", bus.dm_req, 1'b0);
        chk("ld_rdata", readData_M, 64'hDEADBEEF);
        tick();
        MemRead_M = 1'b0; #1;
        chk("ld_back_idle_req", bus.dm_req, 1'b0);
        chk("ld_back_idle_stall", stall_M, 1'b0);

        // Ack outside REQ is ignored
        bus.dm_ack = 1'b1; bus.dm_rdata = 64'hBAD;
        tick();
        chk("stray_ack_rdata", readData_M, 64'hDEADBEEF);
        chk("stray_ack_req", bus.dm_req, 1'b0);
        bus.dm_ack = 1'b0;

        // Store, ack on third REQ cycle
        MemWrite_M = 1'b1; aluResult_M = 64'h80; writeData_M = 64'h1234; #1;
        chk("st_idle_stall", stall_M, 1'b1);
        tick();
        bus.dm_rdata = 64'h5555;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) bus.dm_ack = 1'b1;
            #1;
            chk($sformatf("st_req%0d_req", i), bus.dm_req, 1'b1);
            chk($sformatf("st_req%0d_we", i), bus.dm_we, 1'b1);
            chk($sformatf("st_req%0d_wdata", i), bus.dm_wdata, 64'h1234);
            chk($sformatf("st_req%0d_stall", i), stall_M, 1'b1);
            tick();
        end
        bus.dm_ack = 1'b0; #1;
        chk("st_done_stall", stall_M, 1'b0);
        chk("st_rdata_kept", readData_M, 64'hDEADBEEF);
        tick();
        MemWrite_M = 1'b0; #1;

        // Timeout: 4 REQ cycles without ack, then FAULT
        MemRead_M = 1'b1; aluResult_M = 64'h100;
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_req%0d", i), bus.dm_req, 1'b1);
            chk($sformatf("to_fault%0d", i), mem_fault, 1'b0);
            tick();
        end
        chk("to_fault", mem_fault, 1'b1);
        chk("to_fault_req", bus.dm_req, 1'b0);
        chk("to_fault_stall", stall_M, 1'b0);
        chk("to_fault_pcsrc", PCSrc_M, 1'b1);
        tick(); tick();
        chk("to_later_req", bus.dm_req, 1'b0);
        chk("to_later_fault", mem_fault, 1'b1);

        // Misaligned read faults immediately
        reset = 1'b1; MemRead_M = 1'b0;
        tick();
        reset = 1'b0;
        chk("post_rst_fault", mem_fault, 1'b0);
        chk("post_rst_rdata", readData_M, 64'h0);
        MemRead_M = 1'b1; aluResult_M = 64'h44; #1;
        chk("mis_stall", stall_M, 1'b0);
        tick();
        chk("mis_fault", mem_fault, 1'b1);
        chk("mis_req", bus.dm_req, 1'b0);

        // Read and write together after reset
        reset = 1'b1; MemWrite_M = 1'b1; aluResult_M = 64'h48;
        tick();
        reset = 1'b0;
        chk("both_idle_fault", mem_fault, 1'b0);
        chk("both_stall", stall_M, 1'b0);
        tick();
        chk("both_fault", mem_fault, 1'b1);
        chk("both_req", bus.dm_req, 1'b0);

        // Bus error with ack: FAULT, read data untouched
        reset = 1'b1; MemWrite_M = 1'b0; aluResult_M = 64'h8;
        tick();
        reset = 1'b0; MemRead_M = 1'b0; #1;
        MemRead_M = 1'b1;
        tick();
        chk("err_req", bus.dm_req, 1'b1);
        bus.dm_err = 1'b1; bus.dm_ack = 1'b1; bus.dm_rdata = 64'h77;
        tick();
        bus.dm_err = 1'b0; bus.dm_ack = 1'b0;
        chk("err_fault", mem_fault, 1'b1);
        chk("err_rdata", readData_M, 64'h0);

        // Reset mid-REQ, late ack ignored
        reset = 1'b1; MemRead_M = 1'b0;
        tick();
        reset = 1'b0; MemRead_M = 1'b1; aluResult_M = 64'h10;
        tick();
        chk("mid_req", bus.dm_req, 1'b1);
        reset = 1'b1;
        tick();
        chk("mid_rst_req", bus.dm_req, 1'b0);
        chk("mid_rst_stall", stall_M, 1'b1);
        chk("mid_rst_addr", bus.dm_addr, 64'h0);
        chk("mid_pcsrc", PCSrc_M, 1'b1);
        reset = 1'b0; MemRead_M = 1'b0;
        bus.dm_ack = 1'b1; bus.dm_rdata = 64'hAA;
        tick();
        bus.dm_ack = 1'b0;
        chk("late_ack_rdata", readData_M, 64'h0);
        chk("late_ack_req", bus.dm_req, 1'b0);
        chk("late_ack_stall", stall_M, 1'b0);
        chk("late_ack_fault", mem_fault, 1'b0);
        chk("late_pcsrc", PCSrc_M, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
